// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encodings, the
// architectural zero register index and the load-use hazard compare.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTRL_INIT     = 2'd0,
    PCTRL_RUN      = 2'd1,
    PCTRL_MEM_WAIT = 2'd2,
    PCTRL_REDIRECT = 2'd3
  } pctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  function automatic logic load_use_hazard(
    input logic       d_valid,
    input logic       a_valid,
    input logic       a_is_load,
    input logic [4:0] a_reg_d,
    input logic [4:0] d_reg_s1,
    input logic [4:0] d_reg_s2
  );
    return d_valid & a_valid & a_is_load & (a_reg_d != REG_ZERO) &
           ((a_reg_d == d_reg_s1) | (a_reg_d == d_reg_s2));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that increments on INC and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INC,
  output logic [WIDTH-1:0] CNT
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: start-up hold, memory freeze, branch redirect and
// load-use interlock for the four-stage RV32I pipeline.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 D_VALID,
  input  logic [4:0]           D_REG_S1,
  input  logic [4:0]           D_REG_S2,
  input  logic                 A_VALID,
  input  logic                 A_IS_LOAD,
  input  logic [4:0]           A_REG_D,
  input  logic                 A_BRANCH_TAKEN,
  input  logic [31:0]          A_BRANCH_TARGET,
  input  logic                 M_MEM_REQ,
  input  logic                 M_MEM_ACK,
  output logic                 STALL_F,
  output logic                 STALL_D,
  output logic                 STALL_A,
  output logic                 STALL_M,
  output logic                 FLUSH_D,
  output logic                 FLUSH_A,
  output logic                 PC_REDIRECT,
  output logic [31:0]          PC_REDIRECT_ADDR,
  output logic                 PROTO_ERR,
  output logic [CNT_WIDTH-1:0] CNT_STALL,
  output logic [CNT_WIDTH-1:0] CNT_FLUSH,
  output logic [1:0]           STATE
);

  localparam int IW = $clog2(INIT_CYCLES + 1);

  pctrl_state_e state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic          redir_flag_q, redir_flag_d;
  logic          proto_err_q, proto_err_d;

  logic mem_stall;
  logic run_eval;
  logic stall_f, stall_d, stall_a, stall_m;
  logic flush_d, flush_a, pc_redirect;
  logic stall_any, flush_any;

  assign mem_stall = M_MEM_REQ & ~M_MEM_ACK;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    redir_flag_d = redir_flag_q;
    proto_err_d  = proto_err_q;
    run_eval     = 1'b0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_a      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_a      = 1'b0;
    pc_redirect  = 1'b0;

    case (state_q)
      PCTRL_INIT: begin
        {stall_f, stall_d, stall_a, stall_m} = 4'b1111;
        {flush_d, flush_a}                   = 2'b11;
        init_cnt_d = init_cnt_q - IW'(1);
        if (init_cnt_q <= IW'(1)) begin
          state_d = PCTRL_RUN;
        end
      end
      PCTRL_RUN: begin
        if (mem_stall) begin
          {stall_f, stall_d, stall_a, stall_m} = 4'b1111;
          state_d = PCTRL_MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      PCTRL_MEM_WAIT: begin
        if (!M_MEM_REQ && !M_MEM_ACK) begin
          proto_err_d = 1'b1;
        end
        if (mem_stall) begin
          {stall_f, stall_d, stall_a, stall_m} = 4'b1111;
        end else begin
          // Exit cycle behaves as RUN; an interrupted redirect flush resumes next.
          run_eval     = 1'b1;
          state_d      = redir_flag_q ? PCTRL_REDIRECT : PCTRL_RUN;
          redir_flag_d = 1'b0;
        end
      end
      PCTRL_REDIRECT: begin
        if (mem_stall) begin
          {stall_f, stall_d, stall_a, stall_m} = 4'b1111;
          state_d      = PCTRL_MEM_WAIT;
          redir_flag_d = 1'b1;
        end else begin
          flush_d = 1'b1;
          state_d = PCTRL_RUN;
        end
      end
      default: state_d = PCTRL_INIT;
    endcase

    if (run_eval) begin
      if (A_VALID && A_BRANCH_TAKEN) begin
        pc_redirect = 1'b1;
        flush_d     = 1'b1;
        flush_a     = 1'b1;
        state_d     = PCTRL_REDIRECT;
      end else if (load_use_hazard(D_VALID, A_VALID, A_IS_LOAD, A_REG_D,
                                   D_REG_S1, D_REG_S2)) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_a = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= PCTRL_INIT;
      init_cnt_q   <= IW'(INIT_CYCLES);
      redir_flag_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      redir_flag_q <= redir_flag_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign stall_any = (stall_f | stall_d | stall_a | stall_m) & (state_q != PCTRL_INIT);
  assign flush_any = (flush_d | flush_a) & (state_q != PCTRL_INIT);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_stall (
    .CLK (CLK),
    .RST (RST),
    .INC (stall_any),
    .CNT (CNT_STALL)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_flush (
    .CLK (CLK),
    .RST (RST),
    .INC (flush_any),
    .CNT (CNT_FLUSH)
  );

  assign STALL_F          = stall_f;
  assign STALL_D          = stall_d;
  assign STALL_A          = stall_a;
  assign STALL_M          = stall_m;
  assign FLUSH_D          = flush_d;
  assign FLUSH_A          = flush_a;
  assign PC_REDIRECT      = pc_redirect;
  assign PC_REDIRECT_ADDR = pc_redirect ? A_BRANCH_TARGET : 32'd0;
  assign PROTO_ERR        = proto_err_q;
  assign STATE            = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each cycle's expected controls are
// queued as stimulus is applied and checked at the following falling edge.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          D_VALID, A_VALID, A_IS_LOAD, A_BRANCH_TAKEN, M_MEM_REQ, M_MEM_ACK;
  logic [4:0]    D_REG_S1, D_REG_S2, A_REG_D;
  logic [31:0]   A_BRANCH_TARGET;
  logic          STALL_F, STALL_D, STALL_A, STALL_M, FLUSH_D, FLUSH_A;
  logic          PC_REDIRECT, PROTO_ERR;
  logic [31:0]   PC_REDIRECT_ADDR;
  logic [CW-1:0] CNT_STALL, CNT_FLUSH;
  logic [1:0]    STATE;

  pipeline_ctrl #(.INIT_CYCLES(4), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST),
    .D_VALID(D_VALID), .D_REG_S1(D_REG_S1), .D_REG_S2(D_REG_S2),
    .A_VALID(A_VALID), .A_IS_LOAD(A_IS_LOAD), .A_REG_D(A_REG_D),
    .A_BRANCH_TAKEN(A_BRANCH_TAKEN), .A_BRANCH_TARGET(A_BRANCH_TARGET),
    .M_MEM_REQ(M_MEM_REQ), .M_MEM_ACK(M_MEM_ACK),
    .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_A(STALL_A), .STALL_M(STALL_M),
    .FLUSH_D(FLUSH_D), .FLUSH_A(FLUSH_A),
    .PC_REDIRECT(PC_REDIRECT), .PC_REDIRECT_ADDR(PC_REDIRECT_ADDR),
    .PROTO_ERR(PROTO_ERR), .CNT_STALL(CNT_STALL), .CNT_FLUSH(CNT_FLUSH),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [3:0]  stl;
    logic [1:0]  fl;
    logic        rd;
    logic [31:0] addr;
    logic        pe;
  } exp_t;

  exp_t          sb_q[$];
  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [CW-1:0] exp_cnt_stall = '0;
  logic [CW-1:0] exp_cnt_flush = '0;

  localparam logic [3:0] ALL  = 4'b1111;
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] FD   = 4'b1100;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [4:0] s1, input logic [4:0] s2,
                       input logic av, input logic ld, input logic [4:0] rd,
                       input logic tk, input logic [31:0] tgt,
                       input logic req, input logic ack);
    D_VALID = dv; D_REG_S1 = s1; D_REG_S2 = s2;
    A_VALID = av; A_IS_LOAD = ld; A_REG_D = rd;
    A_BRANCH_TAKEN = tk; A_BRANCH_TARGET = tgt;
    M_MEM_REQ = req; M_MEM_ACK = ack;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic mem(input logic req, input logic ack);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, req, ack);
  endtask

  task automatic step(input string tag, input logic [1:0] st, input logic [3:0] stl,
                      input logic [1:0] fl, input logic rd, input logic [31:0] addr,
                      input logic pe);
    exp_t e;
    exp_t o;
    e.tag = tag; e.st = st; e.stl = stl; e.fl = fl; e.rd = rd; e.addr = addr; e.pe = pe;
    sb_q.push_back(e);
    @(negedge CLK);
    o = sb_q.pop_front();
    check_eq({o.tag, ".state"}, 32'(STATE), 32'(o.st));
    check_eq({o.tag, ".stall"}, 32'({STALL_F, STALL_D, STALL_A, STALL_M}), 32'(o.stl));
    check_eq({o.tag, ".flush"}, 32'({FLUSH_D, FLUSH_A}), 32'(o.fl));
    check_eq({o.tag, ".redir"}, 32'(PC_REDIRECT), 32'(o.rd));
    check_eq({o.tag, ".addr"}, PC_REDIRECT_ADDR, o.addr);
    check_eq({o.tag, ".proto"}, 32'(PROTO_ERR), 32'(o.pe));
    check_eq({o.tag, ".cnt_stall"}, 32'(CNT_STALL), 32'(exp_cnt_stall));
    check_eq({o.tag, ".cnt_flush"}, 32'(CNT_FLUSH), 32'(exp_cnt_flush));
    $display("[TB] %s state=%0d stall=%b flush=%b redir=%0b addr=%08h proto=%0b cs=%0d cf=%0d",
             o.tag, STATE, {STALL_F, STALL_D, STALL_A, STALL_M}, {FLUSH_D, FLUSH_A},
             PC_REDIRECT, PC_REDIRECT_ADDR, PROTO_ERR, CNT_STALL, CNT_FLUSH);
    if (!RST && o.st != 2'd0) begin
      if ((o.stl != 4'd0) && (exp_cnt_stall != '1)) exp_cnt_stall++;
      if ((o.fl != 2'd0) && (exp_cnt_flush != '1)) exp_cnt_flush++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic startup(input string tag);
    for (int i = 0; i < 4; i++) begin
      step({tag, "_init"}, 2'd0, ALL, 2'b11, 1'b0, 32'd0, 1'b0);
    end
    step({tag, "_run"}, 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    step("reset", 2'd0, ALL, 2'b11, 1'b0, 32'd0, 1'b0);
    RST = 1'b0;
    startup("boot");

    // Load-use on rs1, then x0 destination, then rs2 match, then no decode valid.
    drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
    step("lu_rs1", 2'd1, FD, 2'b01, 1'b0, 32'd0, 1'b0);
    idle();
    step("lu_after", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("lu_x0", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0, 1'b0, 1'b0);
    step("lu_rs2", 2'd1, FD, 2'b01, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0, 1'b0, 1'b0);
    step("lu_novalid", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);

    // Taken branch; hazard inputs during REDIRECT must be ignored.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    step("br", 2'd1, NONE, 2'b11, 1'b1, 32'h100, 1'b0);
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    step("br_redir", 2'd3, NONE, 2'b10, 1'b0, 32'd0, 1'b0);
    idle();
    step("br_run", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);

    // REQ held three cycles with ACK on the third.
    mem(1'b1, 1'b0);
    step("mem_req1", 2'd1, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    step("mem_req2", 2'd2, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    mem(1'b1, 1'b1);
    step("mem_ack", 2'd2, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    step("mem_fast", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    idle();
    step("mem_run", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);

    // Branch held across a memory stall redirects once, on the ACK cycle.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_2000, 1'b1, 1'b0);
    step("brm_req1", 2'd1, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    step("brm_req2", 2'd2, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
    step("brm_ack", 2'd2, NONE, 2'b11, 1'b1, 32'h2000, 1'b0);
    idle();
    step("brm_redir", 2'd3, NONE, 2'b10, 1'b0, 32'd0, 1'b0);
    step("brm_run", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);

    // Memory stall hits the REDIRECT cycle; its flush resumes after ACK.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    step("rdm_br", 2'd1, NONE, 2'b11, 1'b1, 32'h40, 1'b0);
    mem(1'b1, 1'b0);
    step("rdm_stall", 2'd3, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    step("rdm_wait", 2'd2, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    mem(1'b1, 1'b1);
    step("rdm_ack", 2'd2, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    idle();
    step("rdm_resume", 2'd3, NONE, 2'b10, 1'b0, 32'd0, 1'b0);
    step("rdm_run", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);

    // Long stall drives the stall counter into saturation.
    mem(1'b1, 1'b0);
    step("sat_req", 2'd1, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step("sat_wait", 2'd2, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    end
    mem(1'b1, 1'b1);
    step("sat_ack", 2'd2, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    idle();
    step("sat_run", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);

    // REQ dropped without ACK sets the sticky protocol error.
    mem(1'b1, 1'b0);
    step("pe_req1", 2'd1, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    step("pe_req2", 2'd2, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    idle();
    step("pe_drop", 2'd2, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    step("pe_sticky1", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b1);
    step("pe_sticky2", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b1);

    // Reset while waiting with the redirect flag set.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    step("rst_br", 2'd1, NONE, 2'b11, 1'b1, 32'h80, 1'b1);
    mem(1'b1, 1'b0);
    step("rst_stall", 2'd3, ALL, 2'b00, 1'b0, 32'd0, 1'b1);
    step("rst_wait", 2'd2, ALL, 2'b00, 1'b0, 32'd0, 1'b1);
    RST = 1'b1;
    exp_cnt_stall = '0;
    exp_cnt_flush = '0;
    step("rst_mid", 2'd0, ALL, 2'b11, 1'b0, 32'd0, 1'b0);
    RST = 1'b0;
    idle();
    startup("reboot");
    mem(1'b1, 1'b0);
    step("flag_req", 2'd1, ALL, 2'b00, 1'b0, 32'd0, 1'b0);
    mem(1'b1, 1'b1);
    step("flag_ack", 2'd2, NONE, 2'b00, 1'b0, 32'd0, 1'b0);
    idle();
    step("flag_clear", 2'd1, NONE, 2'b00, 1'b0, 32'd0, 1'b0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
